// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control sequencer for a MIPS datapath. Steps one
//             shared memory, the ALU and the register file through fetch,
//             decode, execute, memory and writeback phases. The memory side
//             uses a ready handshake, so memory latency can vary. A
//             retired-instruction counter and an illegal-opcode pulse are
//             provided for debug.
//
//  Build option:
//    MC_JUMP_EN  - when defined, opcode 000010 (J) is decoded and the JUMP
//                  state exists. When undefined, J is treated as illegal.
//
//  Parameters:
//    CNT_W        width of the retired-instruction counter
//
//  Ports:
//    clk          system clock, rising edge
//    rst_n        asynchronous active-low reset
//    opCode       instruction[31:26] from the instruction register
//    zero         ALU zero flag (the datapath qualifies pcWriteCond with it)
//    mem_ready    memory completes the current read/write this cycle
//    pcWrite      unconditional PC load
//    pcWriteCond  PC load if zero
//    iOrD         memory address select: 0 PC, 1 ALUOut
//    memRead      memory read request
//    memWrite     memory write request
//    irWrite      instruction register load
//    memToReg     writeback select: 0 ALUOut, 1 MDR
//    regWrite     register file write
//    regDist      destination select: 0 rt, 1 rd
//    ALUSrcA      0 PC, 1 rs
//    ALUSrcB      00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//    aluOp        000 R-type (funct decides), 001 add, 010 subtract
//    pcSource     00 ALU result, 01 ALUOut, 10 jump target
//    state        current state encoding
//    illegal      one-cycle pulse in DECODE on an unsupported opcode
//    instr_count  retired instructions, wraps
//
//  Revision : 1.0  initial release
// ============================================================================
module mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opCode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iOrD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regWrite,
    output logic             regDist,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    // ------------------------------------------------------------------
    // State encoding. Without the jump option, code 11 is simply one more
    // unused encoding and recovers to FETCH like 12..15.
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10
`ifdef MC_JUMP_EN
        ,
        JUMP   = 4'd11
`endif
    } state_t;

    // Moore control word, held in a register and loaded with the value
    // belonging to the state being entered.
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       reg_dst;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctl_t;

    state_t     cur;
    state_t     nxt;
    ctl_t       ctl;
    logic       retire;
    logic       bad_op;
    logic       fetch_hs;

    // The zero flag is consumed by the datapath together with pcWriteCond;
    // the sequencer itself never branches on it.
    logic       unused_zero;
    assign unused_zero = zero;

    // ------------------------------------------------------------------
    // Moore output table; anything not listed for a state is 0.
    // ------------------------------------------------------------------
    function automatic ctl_t moore_out(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_rd = 1'b1;
                c.src_b  = 2'b01;
                c.alu_op = 3'b001;
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut.
                c.src_b  = 2'b11;
                c.alu_op = 3'b001;
            end
            MEMADR: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'b10;
                c.alu_op = 3'b001;
            end
            MEMRD: begin
                c.mem_rd = 1'b1;
                c.i_or_d = 1'b1;
            end
            MEMWB: begin
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_wr = 1'b1;
                c.i_or_d = 1'b1;
            end
            EXEC: begin
                c.src_a  = 1'b1;
                c.alu_op = 3'b000;
            end
            RWB: begin
                c.reg_wr  = 1'b1;
                c.reg_dst = 1'b1;
            end
            BRANCH: begin
                c.src_a      = 1'b1;
                c.alu_op     = 3'b010;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = 2'b01;
            end
            ADDIEX: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'b10;
                c.alu_op = 3'b001;
            end
            ADDIWB: begin
                c.reg_wr = 1'b1;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                c.pc_wr  = 1'b1;
                c.pc_src = 2'b10;
            end
`endif
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Next-state, retire and illegal-opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        bad_op = 1'b0;
        case (cur)
            FETCH: begin
                if (mem_ready) begin
                    nxt = DECODE;
                end
            end
            DECODE: begin
                case (opCode)
                    OP_R:          nxt = EXEC;
                    OP_LW, OP_SW:  nxt = MEMADR;
                    OP_BEQ:        nxt = BRANCH;
                    OP_ADDI:       nxt = ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:          nxt = JUMP;
`endif
                    default: begin
                        bad_op = 1'b1;
                        nxt    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                // Only LW and SW reach this state; IR is stable meanwhile.
                nxt = (opCode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                if (mem_ready) begin
                    nxt = MEMWB;
                end
            end
            MEMWB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            MEMWR: begin
                if (mem_ready) begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end
            end
            EXEC: begin
                nxt = RWB;
            end
            RWB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            BRANCH: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            ADDIEX: begin
                nxt = ADDIWB;
            end
            ADDIWB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
`endif
            default: begin
                // Unused encodings recover without counting an instruction.
                nxt = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, registered control word and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= FETCH;
            ctl         <= moore_out(FETCH);
            instr_count <= '0;
        end else begin
            cur <= nxt;
            ctl <= moore_out(nxt);
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Write/request strobes are qualified with rst_n so that an
    // asserted reset silences the memory and register file in the same
    // cycle, even though the control word holds the FETCH values (which
    // include a read request) while in reset.
    // ------------------------------------------------------------------
    assign fetch_hs    = (cur == FETCH) && mem_ready && rst_n;

    assign irWrite     = fetch_hs;
    assign pcWrite     = (ctl.pc_wr && rst_n) || fetch_hs;
    assign pcWriteCond = ctl.pc_wr_cond && rst_n;
    assign memRead     = ctl.mem_rd && rst_n;
    assign memWrite    = ctl.mem_wr && rst_n;
    assign regWrite    = ctl.reg_wr && rst_n;

    assign iOrD        = ctl.i_or_d;
    assign memToReg    = ctl.mem_to_reg;
    assign regDist     = ctl.reg_dst;
    assign ALUSrcA     = ctl.src_a;
    assign ALUSrcB     = ctl.src_b;
    assign aluOp       = ctl.alu_op;
    assign pcSource    = ctl.pc_src;

    assign state       = cur;
    assign illegal     = bad_op && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Scoreboard bench for mc_control (CNT_W = 4). The driver sets
//             inputs once per cycle and queues the expected state, control
//             outputs, illegal flag and counter for that cycle; a monitor
//             on the falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opCode;
    logic             zero;
    logic             mem_ready;
    logic             pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
    logic             memToReg, regWrite, regDist, ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       aluOp;
    logic [1:0]       pcSource;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opCode      (opCode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iOrD        (iOrD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regWrite    (regWrite),
        .regDist     (regDist),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .aluOp       (aluOp),
        .pcSource    (pcSource),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order: pcWrite pcWriteCond iOrD memRead memWrite irWrite memToReg
    //        regWrite regDist ALUSrcA ALUSrcB[1:0] aluOp[2:0] pcSource[1:0]
    logic [16:0] dut_outs;
    assign dut_outs = {pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite,
                       memToReg, regWrite, regDist, ALUSrcA, ALUSrcB, aluOp,
                       pcSource};

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      outs;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    logic [CNT_W-1:0] exp_cnt;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    // Control-output table written from the state descriptions.
    function automatic logic [16:0] spec_out(input logic [3:0] st,
                                             input logic rdy,
                                             input logic in_rst);
        logic       pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa;
        logic [1:0] sbv, ps;
        logic [2:0] op;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa} = '0;
        sbv = 2'b00; ps = 2'b00; op = 3'b000;
        case (st)
            4'd0:  begin mr = 1; sbv = 2'b01; op = 3'b001; irw = rdy; pw = rdy; end
            4'd1:  begin sbv = 2'b11; op = 3'b001; end
            4'd2:  begin sa = 1; sbv = 2'b10; op = 3'b001; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin sa = 1; sbv = 2'b00; op = 3'b000; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; op = 3'b010; pwc = 1; ps = 2'b01; end
            4'd9:  begin sa = 1; sbv = 2'b10; op = 3'b001; end
            4'd10: begin rw = 1; end
            4'd11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        if (in_rst) begin
            {pw, pwc, mr, mw, irw, rw} = '0;
        end
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa, sbv, op, ps};
    endfunction

    // Monitor: every cycle with a queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (state !== e.st) begin
                fails++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
            end
            tests++;
            if (dut_outs !== e.outs) begin
                fails++;
                $display("FAIL outs @%0t state %0d: got %b expected %b", $time, e.st, dut_outs, e.outs);
            end
            tests++;
            if (illegal !== e.ill) begin
                fails++;
                $display("FAIL illegal @%0t: got %b expected %b", $time, illegal, e.ill);
            end
            tests++;
            if (instr_count !== e.cnt) begin
                fails++;
                $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, e.cnt);
            end
        end
    end

    // One cycle: entered 1 time unit after a rising edge. rst_mid asserts
    // reset 2 units later, before the monitor samples, with no clock edge
    // in between.
    task automatic step(input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic ill,
                        input logic rst_mid);
        exp_t e;
        opCode    = op;
        mem_ready = rdy;
        if (rst_mid) begin
            #2;
            rst_n   = 1'b0;
            exp_cnt = '0;
        end
        e.st   = st;
        e.outs = spec_out(st, rdy, !rst_n);
        e.ill  = ill;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // seq holds one expected state per nibble (cycle 0 in bits 3:0);
    // rdy holds mem_ready per cycle.
    task automatic instr(input logic [5:0] op, input logic [31:0] seq,
                         input logic [7:0] rdy, input int n,
                         input logic ill, input logic retire);
        for (int i = 0; i < n; i++) begin
            step(op, rdy[i], seq[4*i +: 4], ill && (seq[4*i +: 4] == 4'd1), 1'b0);
        end
        if (retire) begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opCode    = R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        exp_cnt   = '0;
        @(posedge clk);
        #1;
        // Reset state
        step(R, 1'b1, 4'd0, 1'b0, 1'b0);
        step(R, 1'b0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // R-type: 0,1,6,7
        instr(R, 32'h0000_7610, 8'hFF, 4, 1'b0, 1'b1);
        // LW with three memory stalls: 0,1,2,3,3,3,3,4
        instr(LW, 32'h4333_3210, 8'b1100_0111, 8, 1'b0, 1'b1);
        // BEQ with zero set: 0,1,8
        zero = 1'b1;
        instr(BEQ, 32'h0000_0810, 8'hFF, 3, 1'b0, 1'b1);
        zero = 1'b0;
        // SW with a fetch stall: 0,0,1,2,5
        instr(SW, 32'h0005_2100, 8'b0001_1110, 5, 1'b0, 1'b1);
        // Unsupported opcode: pulse in DECODE, back to FETCH, not counted
        instr(BAD, 32'h0000_0010, 8'hFF, 2, 1'b1, 1'b0);
`ifdef MC_JUMP_EN
        instr(J, 32'h0000_0B10, 8'hFF, 3, 1'b0, 1'b1);
`else
        instr(J, 32'h0000_0010, 8'hFF, 2, 1'b1, 1'b0);
`endif
        // SW stalled in MEMWR, then reset asserted mid-cycle
        step(SW, 1'b1, 4'd0, 1'b0, 1'b0);
        step(SW, 1'b1, 4'd1, 1'b0, 1'b0);
        step(SW, 1'b1, 4'd2, 1'b0, 1'b0);
        step(SW, 1'b0, 4'd5, 1'b0, 1'b0);
        step(SW, 1'b0, 4'd0, 1'b0, 1'b1);
        step(ADDI, 1'b1, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 16 ADDI instructions: counter wraps back to 0
        for (int k = 0; k < 16; k++) begin
            instr(ADDI, 32'h0000_A910, 8'hFF, 4, 1'b0, 1'b1);
        end
        step(ADDI, 1'b0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle opcode decode with a Moore/Mealy FSM that steps one shared memory, the ALU and the register file through fetch, decode, execute, memory and writeback phases. The memory side uses a ready handshake, so memory latency can vary. A retired-instruction counter and an illegal-opcode flag support debug.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opCode  input  6  instruction[31:26] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if zero
- iOrD  output  1  memory address select: 0 PC, 1 ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  instruction register load
- memToReg  output  1  writeback select: 0 ALUOut, 1 MDR
- regWrite  output  1  register file write
- regDist  output  1  dest select: 0 rt, 1 rd
- ALUSrcA  output  1  0 PC, 1 rs
- ALUSrcB  output  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- aluOp  output  3  000 R-type (funct decides), 001 add, 010 subtract
- pcSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- state  output  4  current state encoding
- illegal  output  1  one-cycle pulse on unsupported opcode
- instr_count  output  CNT_W  retired instructions, wraps

## Operation
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010 (macro-gated).
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
  - FETCH: memRead=1, iOrD=0, ALUSrcA=0, ALUSrcB=01, aluOp=001, pcSource=00.
  - FETCH, mem_ready=1 only: irWrite=1 and pcWrite=1, then go to DECODE. Otherwise hold FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, aluOp=001 (branch target). Dispatch: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP.
  - DECODE, any other opcode: illegal=1, go to FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, aluOp=001. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: memRead=1, iOrD=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: regWrite=1, memToReg=1, regDist=0.
  - MEMWR: memWrite=1, iOrD=1. Hold until mem_ready, then go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, aluOp=000.
  - RWB: regWrite=1, memToReg=0, regDist=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, aluOp=010, pcWriteCond=1, pcSource=01.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, aluOp=001.
  - ADDIWB: regWrite=1, memToReg=0, regDist=0.
  - JUMP: pcWrite=1, pcSource=10.
- Unlisted outputs in any state are 0.
- Terminal states return to FETCH: MEMWB, MEMWR (on ready), RWB, BRANCH, ADDIWB, JUMP.
- instr_count increments by 1 on each terminal→FETCH transition and wraps from 2^CNT_W−1 to 0. It does not increment on illegal.
- Unused state encodings 12–15 go to FETCH on the next edge. The transition is not counted.
- memRead/memWrite stay asserted, with a stable address select, for as long as the FSM holds waiting for mem_ready.

## Timing
- Reset, while rst_n=0:
  - state=FETCH, instr_count=0, illegal=0.
  - pcWrite, pcWriteCond, irWrite, regWrite, memWrite and memRead forced to 0.
  - Muxes at their FETCH values.
- First request is issued in the first cycle after rst_n rises.
- Cycles per instruction with mem_ready tied high: R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3. Each memory stall adds 1 cycle.
- irWrite and pcWrite in FETCH are Mealy outputs, combinational on mem_ready. All other outputs are Moore outputs.
- rst_n falling mid-instruction aborts immediately. No partial writes are issued after the reset assertion.

## Configuration
- MC_JUMP_EN defined: opcode 000010 goes to JUMP and pcSource=10 is reachable.
- MC_JUMP_EN undefined: opcode 000010 is illegal (illegal pulse, return to FETCH, not counted). JUMP state is absent and pcSource never equals 10.

## Test plan
- Reset, mem_ready=1, opCode=000000 → state sequence 0,1,6,7,0. regWrite=1 and regDist=1 in the RWB cycle. instr_count=1.
- LW with mem_ready low for 3 cycles in MEMRD → memRead=1 and iOrD=1 held for 4 cycles. Total 8 cycles. regWrite=1 and memToReg=1 in MEMWB.
- BEQ with zero=1 → pcWriteCond=1, aluOp=010, pcSource=01 in state 8. Returns to FETCH after 3 cycles.
- opCode=111111 → illegal pulses for 1 cycle in DECODE. Next state FETCH. instr_count unchanged.
- opCode=000010: with MC_JUMP_EN, pcWrite=1 and pcSource=10 in state 11. Without it, illegal=1.
- CNT_W=4: 16 ADDI instructions → instr_count returns to 0. Asserting rst_n low in MEMWR → memWrite drops to 0 immediately and state=0.
